cnt_ld_sched: RTL and testbench

- Round-robin scheduler that shares one internal loadable up-counter among N_REQ requesters, each needing a programmable delay.
- Arbitrates requests, loads the counter, counts to the winner's requested length, then pulses that requester's done.
- Sits between timing clients (e.g. FSMs needing wait states) and the shared counter datapath.

---
 rtl/cnt_ld_sched.sv | 173 +++++++++++++++++
 tb/tb_cnt_ld_sched.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_ld_sched.sv
// Round-robin scheduler sharing one loadable up-counter among N_REQ timing clients.
// Optional abort input/aborted output are built in when CNT_LD_SCHED_ABORT_EN is defined.
module cnt_ld_sched #(
  parameter  int N_REQ = 4,
  parameter  int W     = 8,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               en,
`ifdef CNT_LD_SCHED_ABORT_EN
  input  logic               abort,
  output logic               aborted,
`endif
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] len,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done,
  output logic               busy,
  output logic [IDW-1:0]     cur_id,
  output logic [W-1:0]       q
);

  // Handshake: req[i] is a level held by the client until done[i] pulses;
  // grant[i] marks the single LOAD cycle in which len[i] has already been latched.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [IDW:0]     NREQ_V = (IDW+1)'(N_REQ);
  localparam logic [N_REQ-1:0] ONE_V  = N_REQ'(1);

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [IDW-1:0] cur_id_q, cur_id_d;
  logic [W-1:0]   len_lat_q, len_lat_d;
  logic [W-1:0]   q_q, q_d;

  logic [N_REQ-1:0] req_rot;
  logic             pick_found;
  logic [IDW:0]     pick_off;
  logic [IDW:0]     pick_sum;
  logic [IDW-1:0]   pick_id;
  logic [W-1:0]     len_sel;
  logic [IDW:0]     rr_inc;
  logic [IDW-1:0]   next_rr;

`ifdef CNT_LD_SCHED_ABORT_EN
  logic aborted_q, aborted_d;
`endif

  // req_rot[i] corresponds to requester (rr_q + i) mod N_REQ.
  always_comb begin
    req_rot    = N_REQ'({req, req} >> rr_q);
    pick_found = 1'b0;
    pick_off   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!pick_found && req_rot[i]) begin
        pick_found = 1'b1;
        pick_off   = (IDW+1)'(i);
      end
    end
    pick_sum = {1'b0, rr_q} + pick_off;
    if (pick_sum >= NREQ_V) begin
      pick_sum = pick_sum - NREQ_V;
    end
    pick_id = pick_sum[IDW-1:0];
  end

  always_comb begin
    len_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_id == IDW'(i)) begin
        len_sel = len[i*W +: W];
      end
    end
  end

  always_comb begin
    rr_inc = {1'b0, cur_id_q} + (IDW+1)'(1);
    if (rr_inc == NREQ_V) begin
      next_rr = '0;
    end else begin
      next_rr = rr_inc[IDW-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    cur_id_d  = cur_id_q;
    len_lat_d = len_lat_q;
    q_d       = q_q;
`ifdef CNT_LD_SCHED_ABORT_EN
    aborted_d = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          cur_id_d  = pick_id;
          len_lat_d = len_sel;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        q_d     = '0;
        state_d = S_COUNT;
      end
      S_COUNT: begin
        if (en) begin
          if (q_q == len_lat_q) begin
            state_d = S_DONE;
          end else begin
            q_d = q_q + W'(1);
          end
        end
      end
      S_DONE: begin
        rr_d    = next_rr;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef CNT_LD_SCHED_ABORT_EN
    // Abort overrides en and the terminal-count test; the client loses its turn.
    if (abort && (state_q == S_LOAD || state_q == S_COUNT)) begin
      state_d   = S_IDLE;
      q_d       = '0;
      rr_d      = next_rr;
      aborted_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      cur_id_q  <= '0;
      len_lat_q <= '0;
      q_q       <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      cur_id_q  <= cur_id_d;
      len_lat_q <= len_lat_d;
      q_q       <= q_d;
    end
  end

`ifdef CNT_LD_SCHED_ABORT_EN
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= aborted_d;
    end
  end

  assign aborted = aborted_q;
`endif

  assign grant  = (state_q == S_LOAD) ? (ONE_V << cur_id_q) : '0;
  assign done   = (state_q == S_DONE) ? (ONE_V << cur_id_q) : '0;
  assign busy   = (state_q != S_IDLE);
  assign cur_id = cur_id_q;
  assign q      = q_q;

endmodule

// File: tb/tb_cnt_ld_sched.sv
// Bench for cnt_ld_sched: scenario tasks with inline checks plus a done-pulse scoreboard.
module tb_cnt_ld_sched;

  localparam int N_REQ = 4;
  localparam int W     = 8;
  localparam int IDW   = 2;

  logic               Clk = 1'b0;
  logic               reset;
  logic               en;
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] len;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   done;
  logic               busy;
  logic [IDW-1:0]     cur_id;
  logic [W-1:0]       q;
`ifdef CNT_LD_SCHED_ABORT_EN
  logic               abort;
  logic               aborted;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [W-1:0] mon_id;
  int           mon_cyc;

  cnt_ld_sched #(.N_REQ(N_REQ), .W(W)) dut (
    .Clk    (Clk),
    .reset  (reset),
    .en     (en),
`ifdef CNT_LD_SCHED_ABORT_EN
    .abort  (abort),
    .aborted(aborted),
`endif
    .req    (req),
    .len    (len),
    .grant  (grant),
    .done   (done),
    .busy   (busy),
    .cur_id (cur_id),
    .q      (q)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [N_REQ-1:0] oh(input int i);
    logic [N_REQ-1:0] one;
    one = N_REQ'(1);
    return one << i;
  endfunction

  // ---------------- scoreboard on done pulses ----------------
  always @(negedge Clk) begin
    if (!reset && done !== '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected got=%b cyc=%0d required=none", done, cyc);
      end else begin
        mon_id  = exp_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        if (done !== oh(int'(mon_id)) || cyc != mon_cyc) begin
          errors++;
          $display("FAIL done_sb got=%b@%0d required=%b@%0d", done, cyc, oh(int'(mon_id)), mon_cyc);
        end
      end
    end
  end

  // ---------------- driver / scenario tasks ----------------
  task automatic test_reset();
    bit found;
    repeat (2) @(negedge Clk);
    checks++;
    if ({grant, done, busy, q, cur_id} !== '0) begin
      errors++;
      $display("FAIL reset_values got=%b required=0", {grant, done, busy, q, cur_id});
    end
    reset = 1'b0;
    @(negedge Clk);
    req = 4'b0010;
    len[1*W +: W] = 8'd9;
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge Clk);
      if (busy === 1'b1 && grant === '0 && q === 8'd5) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_wait_q5 got=q%0d required=q5", q);
    end
    reset = 1'b1;
    req = '0;
    #1;
    checks++;
    if ({grant, done, busy, q, cur_id} !== '0) begin
      errors++;
      $display("FAIL reset_midcount got=%b required=0", {grant, done, busy, q, cur_id});
    end
    @(negedge Clk);
    reset = 1'b0;
    found = 1'b0;
    repeat (15) begin
      @(negedge Clk);
      if (busy !== 1'b0) found = 1'b1;
    end
    checks++;
    if (found) begin
      errors++;
      $display("FAIL reset_idle_after got=busy required=idle");
    end
  endtask

  task automatic test_round_robin();
    int g0, c, k;
    @(negedge Clk);
    len = {4{8'd1}};
    req = 4'b1111;
    en  = 1'b1;
    g0  = cyc + 1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(W'(i % 4));
      exp_cyc_q.push_back(g0 + 5*i + 3);
    end
    for (int n = 0; n < 25; n++) begin
      @(negedge Clk);
      c = cyc - g0;
      k = c / 5;
      checks++;
      if ((c % 5 == 0) ? (grant !== oh(k % 4) || cur_id !== IDW'(k % 4)) : (grant !== '0)) begin
        errors++;
        $display("FAIL rr_grant c=%0d got=%b/%0d required=%b", c, grant, cur_id,
                 (c % 5 == 0) ? oh(k % 4) : 4'b0);
      end
      if (c % 5 == 4) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL rr_idle c=%0d got=%b required=0", c, busy);
        end
      end
      if (c % 5 == 3 && k >= 1) req[k % 4] = 1'b0;
    end
  endtask

  task automatic serve_one(input int id, input int ln, input int stall_at, input int stall_n,
                           input bit drop_early);
    int g, qe;
    @(negedge Clk);
    len[id*W +: W] = W'(ln);
    req[id] = 1'b1;
    en = 1'b1;
    g = cyc + 1;
    exp_q.push_back(W'(id));
    exp_cyc_q.push_back(g + ln + 2 + stall_n);
    @(negedge Clk);
    checks++;
    if (grant !== oh(id) || busy !== 1'b1 || cur_id !== IDW'(id)) begin
      errors++;
      $display("FAIL grant_%0d got=%b/%0d/%b required=%b/%0d/1", id, grant, cur_id, busy, oh(id), id);
    end
    len[id*W +: W] = ~W'(ln);
    if (drop_early) req[id] = 1'b0;
    qe = 0;
    for (int n = 0; n <= ln; n++) begin
      @(negedge Clk);
      checks++;
      if (q !== W'(qe) || busy !== 1'b1 || grant !== '0 || done !== '0) begin
        errors++;
        $display("FAIL count_%0d got=q%0d b%b required=q%0d b1", id, q, busy, qe);
      end
      if (stall_n > 0 && qe == stall_at) begin
        en = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge Clk);
          checks++;
          if (q !== W'(stall_at) || busy !== 1'b1 || done !== '0) begin
            errors++;
            $display("FAIL stall_%0d got=q%0d b%b required=q%0d b1", id, q, busy, stall_at);
          end
        end
        en = 1'b1;
      end
      qe++;
    end
    @(negedge Clk);
    checks++;
    if (done !== oh(id) || q !== W'(ln) || busy !== 1'b1) begin
      errors++;
      $display("FAIL done_%0d got=%b q%0d required=%b q%0d", id, done, q, oh(id), ln);
    end
    req[id] = 1'b0;
    @(negedge Clk);
    checks++;
    if (busy !== 1'b0 || done !== '0) begin
      errors++;
      $display("FAIL idle_%0d got=b%b d%b required=0", id, busy, done);
    end
  endtask

  task automatic test_single();
    serve_one(2, 3, -1, 0, 1'b0);
  endtask

  task automatic test_zero_len();
    serve_one(0, 0, -1, 0, 1'b1);
  endtask

  task automatic test_en_stall();
    serve_one(1, 4, 2, 3, 1'b0);
  endtask

`ifdef CNT_LD_SCHED_ABORT_EN
  task automatic test_abort();
    bit found;
    int g;
    @(negedge Clk);
    len[3*W +: W] = 8'd10;
    len[0*W +: W] = 8'd2;
    req = 4'b1001;
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge Clk);
      if (busy === 1'b1 && grant === '0 && cur_id === 2'd3 && q === 8'd4) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL abort_wait_q4 got=q%0d required=q4", q);
    end
    abort = 1'b1;
    @(negedge Clk);
    checks++;
    if (busy !== 1'b0 || q !== '0 || aborted !== 1'b1 || done !== '0) begin
      errors++;
      $display("FAIL abort_taken got=b%b q%0d a%b required=b0 q0 a1", busy, q, aborted);
    end
    abort = 1'b0;
    req[3] = 1'b0;
    g = cyc + 1;
    exp_q.push_back(W'(0));
    exp_cyc_q.push_back(g + 4);
    @(negedge Clk);
    checks++;
    if (grant !== 4'b0001 || aborted !== 1'b0) begin
      errors++;
      $display("FAIL abort_next_grant got=%b a%b required=0001 a0", grant, aborted);
    end
    for (int i = 1; i <= 4; i++) begin
      @(negedge Clk);
      if (i == 4) req[0] = 1'b0;
    end
    @(negedge Clk);
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    en    = 1'b0;
    req   = '0;
    len   = '0;
`ifdef CNT_LD_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_round_robin();
    test_single();
    test_zero_len();
    test_en_stall();
`ifdef CNT_LD_SCHED_ABORT_EN
    test_abort();
`endif
    repeat (3) @(negedge Clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_pending got=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
